// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I format tags, opcode constants and the shared field encoder
package rv_pkg;

  localparam int INSN_WIDTH = 32;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } fields_t;

  // Illegal format tags encode to zero; the caller decides whether to drop them.
  function automatic logic [31:0] encode_insn(input logic [2:0] fmt, input fields_t f);
    case (fmt)
      FMT_R:   encode_insn = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I:   encode_insn = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S:   encode_insn = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B:   encode_insn = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                              f.imm[4:1], f.imm[11], f.opcode};
      FMT_U:   encode_insn = {f.imm[31:12], f.rd, f.opcode};
      FMT_J:   encode_insn = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      default: encode_insn = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with extra-bit pointers
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - packs RV32I fields into words and streams them into IMEM
module insn_encoder #(
  parameter int          INSN_WIDTH = rv_pkg::INSN_WIDTH,
  parameter int          ADDR_WIDTH = 5,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [31:0]           in_imm,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [31:0]           wr_addr,
  output logic [INSN_WIDTH-1:0] wr_data,
  output logic                  err,
  output logic [31:0]           words_out
);
  import rv_pkg::*;

  localparam logic [31:0] WRAP_ADDR = BASE_ADDR + 32'(4 * (IMEM_WORDS - 1));

  fields_t     f;
  logic [31:0] word;
  logic        bad;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;

  always_comb begin
    f        = '0;
    f.opcode = in_opcode;
    f.funct3 = in_funct3;
    f.funct7 = in_funct7;
    f.rs1    = in_rs1;
    f.rs2    = in_rs2;
    f.rd     = in_rd;
    f.imm    = in_imm;
    word     = encode_insn(in_fmt, f);
  end

  // Rejected bundles still complete the handshake; they just never reach the FIFO.
  assign bad      = (in_fmt > 3'd5) || (((in_fmt == FMT_B) || (in_fmt == FMT_J)) && in_imm[0]);
  assign in_ready = !rst && !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !bad;
  assign wr_valid = !empty;
  assign pop      = wr_valid && wr_ready;

  sync_fifo #(
    .WIDTH (INSN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (word[INSN_WIDTH-1:0]),
    .full  (full),
    .pop   (pop),
    .dout  (wr_data),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      wr_addr   <= BASE_ADDR;
      words_out <= 32'd0;
    end else begin
      err <= accept && bad;
      if (pop) begin
        wr_addr   <= (wr_addr == WRAP_ADDR) ? BASE_ADDR : wr_addr + 32'd4;
        words_out <= words_out + 32'd1;
      end
    end
  end

endmodule
